l2_flush_ctrl: RTL and testbench

// - Sequencer for L2 flush: sweeps every (set, way), writes back MODIFIED lines, invalidates valid lines.
// - Drives set/clr/incr strobes of the L2 flush registers (ongoing_flush, flush_set, flush_way); reads counters back.
// - Sits in the L2 top between the flush request source and the tag/state array + writeback path.

---
 rtl/l2_flush_ctrl_pkg.sv | 27 ++
 rtl/l2_flush_ctrl.sv | 152 +++++++++++++++
 tb/tb_l2_flush_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_flush_ctrl_pkg.sv
// Shared types for the L2 flush sequencer: line coherence states and FSM states.
package l2_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    LineInvalid   = 2'd0,
    LineShared    = 2'd1,
    LineExclusive = 2'd2,
    LineModified  = 2'd3
  } line_state_e;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StEval,
    StWb,
    StInval,
    StDowngrade,
    StNext,
    StDone
  } flush_state_e;

  // True when idx is the final index of a range of count entries.
  function automatic logic is_last(input int unsigned idx, input int unsigned count);
    return idx == count - 1;
  endfunction

endpackage

// File: rtl/l2_flush_ctrl.sv
// L2 flush sequencer: walks every (set, way), writes back MODIFIED lines and invalidates valid
// ones. Optional clean sweep (write back + downgrade, keep lines valid) under L2_FLUSH_CLEAN_EN.
module l2_flush_ctrl
  import l2_flush_ctrl_pkg::*;
#(
  parameter int unsigned L2_SETS = 256,
  parameter int unsigned L2_WAYS = 8,
  localparam int unsigned SET_BITS = $clog2(L2_SETS),
  localparam int unsigned WAY_BITS = $clog2(L2_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush_req_valid,
  output logic                o_flush_req_ready,
`ifdef L2_FLUSH_CLEAN_EN
  input  logic                i_flush_req_clean,
  output logic                o_downgrade_en,
`endif
  input  logic                i_pause,
  input  logic                i_ongoing_flush,
  input  logic [SET_BITS-1:0] i_flush_set,
  input  logic [WAY_BITS-1:0] i_flush_way,
  output logic                o_set_ongoing_flush,
  output logic                o_clr_ongoing_flush,
  output logic                o_incr_flush_set,
  output logic                o_clr_flush_set,
  output logic                o_incr_flush_way,
  output logic                o_clr_flush_way,
  output logic                o_lookup_en,
  input  logic [1:0]          i_lookup_state,
  output logic                o_wb_valid,
  input  logic                i_wb_ready,
  output logic [SET_BITS-1:0] o_wb_set,
  output logic [WAY_BITS-1:0] o_wb_way,
  output logic                o_inval_en,
  output logic                o_flush_done
);

  flush_state_e r_state;
  flush_state_e w_state_d;
  logic         w_accept;
  logic         w_clean;
  logic         w_last_set;
  logic         w_last_way;
  logic         w_unused_ongoing;

  // Sweep position is owned by the flush register block; ongoing_flush is informational here.
  assign w_unused_ongoing = i_ongoing_flush;

  assign o_flush_req_ready = (r_state == StIdle) && !i_pause;
  assign w_accept          = o_flush_req_ready && i_flush_req_valid;
  assign w_last_set        = is_last(32'(i_flush_set), L2_SETS);
  assign w_last_way        = is_last(32'(i_flush_way), L2_WAYS);
  assign o_wb_set          = i_flush_set;
  assign o_wb_way          = i_flush_way;

`ifdef L2_FLUSH_CLEAN_EN
  logic r_clean;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clean <= 1'b0;
    end else if (w_accept) begin
      r_clean <= i_flush_req_clean;
    end
  end

  assign w_clean        = r_clean;
  assign o_downgrade_en = (r_state == StDowngrade);
`else
  assign w_clean = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d           = r_state;
    o_set_ongoing_flush = 1'b0;
    o_clr_ongoing_flush = 1'b0;
    o_incr_flush_set    = 1'b0;
    o_clr_flush_set     = 1'b0;
    o_incr_flush_way    = 1'b0;
    o_clr_flush_way     = 1'b0;
    o_lookup_en         = 1'b0;
    o_wb_valid          = 1'b0;
    o_inval_en          = 1'b0;
    o_flush_done        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          o_set_ongoing_flush = 1'b1;
          o_clr_flush_set     = 1'b1;
          o_clr_flush_way     = 1'b1;
          w_state_d           = StLookup;
        end
      end
      StLookup: begin
        o_lookup_en = 1'b1;
        w_state_d   = StEval;
      end
      StEval: begin
        // Lookup data is valid this cycle, one after lookup_en.
        case (line_state_e'(i_lookup_state))
          LineModified:                w_state_d = StWb;
          LineShared, LineExclusive:   w_state_d = w_clean ? StNext : StInval;
          default:                     w_state_d = StNext;
        endcase
      end
      StWb: begin
        o_wb_valid = 1'b1;
        if (i_wb_ready) begin
          w_state_d = w_clean ? StDowngrade : StInval;
        end
      end
      StInval: begin
        o_inval_en = 1'b1;
        w_state_d  = StNext;
      end
      StDowngrade: begin
        w_state_d = StNext;
      end
      StNext: begin
        if (!i_pause) begin
          if (!w_last_way) begin
            o_incr_flush_way = 1'b1;
            w_state_d        = StLookup;
          end else if (!w_last_set) begin
            o_clr_flush_way  = 1'b1;
            o_incr_flush_set = 1'b1;
            w_state_d        = StLookup;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        o_clr_ongoing_flush = 1'b1;
        o_flush_done        = 1'b1;
        w_state_d           = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Directed bench for l2_flush_ctrl (4 sets x 2 ways); models the flush registers and line states.
// Build with L2_FLUSH_CLEAN_EN defined to also exercise the clean sweep.
module tb_l2_flush_ctrl;

  localparam int unsigned Sets  = 4;
  localparam int unsigned Ways  = 2;
  localparam int unsigned Lines = Sets * Ways;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       i_clean;
  logic       i_pause;
  logic [1:0] i_lookup_state;
  logic       i_wb_ready;
  logic       ready, set_ong, clr_ong, incr_set, clr_set, incr_way, clr_way;
  logic       lookup_en, wb_valid, inval_en, flush_done, dg_en;
  logic [1:0] wb_set;
  logic       wb_way;

  // Flush register model
  logic       m_ongoing;
  logic [1:0] m_set;
  logic       m_way;

  logic [1:0] mem [Lines];

  int n_checks = 0;
  int n_errors = 0;

  // Per-sweep statistics
  int   n_lookup, n_wb_cyc, n_hs, n_inval, n_dg, n_done, n_incr_way, n_incr_set, paused_incr;
  int   done_at;
  int   lk_cycle [Lines];
  logic [7:0] inval_mask, dg_mask;
  int   last_wb_set, last_wb_way;
  logic ended, aborted;

  l2_flush_ctrl #(
    .L2_SETS(Sets),
    .L2_WAYS(Ways)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .i_flush_req_valid  (i_valid),
    .o_flush_req_ready  (ready),
`ifdef L2_FLUSH_CLEAN_EN
    .i_flush_req_clean  (i_clean),
    .o_downgrade_en     (dg_en),
`endif
    .i_pause            (i_pause),
    .i_ongoing_flush    (m_ongoing),
    .i_flush_set        (m_set),
    .i_flush_way        (m_way),
    .o_set_ongoing_flush(set_ong),
    .o_clr_ongoing_flush(clr_ong),
    .o_incr_flush_set   (incr_set),
    .o_clr_flush_set    (clr_set),
    .o_incr_flush_way   (incr_way),
    .o_clr_flush_way    (clr_way),
    .o_lookup_en        (lookup_en),
    .i_lookup_state     (i_lookup_state),
    .o_wb_valid         (wb_valid),
    .i_wb_ready         (i_wb_ready),
    .o_wb_set           (wb_set),
    .o_wb_way           (wb_way),
    .o_inval_en         (inval_en),
    .o_flush_done       (flush_done)
  );

`ifndef L2_FLUSH_CLEAN_EN
  assign dg_en = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ongoing <= 1'b0;
      m_set     <= '0;
      m_way     <= '0;
    end else begin
      if (set_ong)       m_ongoing <= 1'b1;
      else if (clr_ong)  m_ongoing <= 1'b0;
      if (clr_set)       m_set <= '0;
      else if (incr_set) m_set <= m_set + 2'd1;
      if (clr_way)       m_way <= 1'b0;
      else if (incr_way) m_way <= m_way + 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < int'(Lines); i++) mem[i] = 2'd0;
  endtask

  // One request and sweep. pause_line: line whose NEXT gets 10 stalled cycles (-1 none).
  // wb_delay: cycles wb_ready stays low per writeback. abort_idx: return at first wb of that line.
  task automatic run_sweep(input int pause_line, input int wb_delay, input int abort_idx,
                           input logic clean);
    int   pause_left;
    int   wb_run;
    int   idx;
    logic nxt_ready, nxt_pause, do_ls;
    logic [1:0] nxt_ls;
    n_lookup = 0; n_wb_cyc = 0; n_hs = 0; n_inval = 0; n_dg = 0; n_done = 0;
    n_incr_way = 0; n_incr_set = 0; paused_incr = 0; done_at = -1;
    inval_mask = '0; dg_mask = '0; last_wb_set = -1; last_wb_way = -1;
    ended = 1'b0; aborted = 1'b0; pause_left = 0; wb_run = 0;
    for (int i = 0; i < int'(Lines); i++) lk_cycle[i] = -1;

    @(posedge clk); #1;
    i_valid = 1'b1;
    i_clean = clean;
    @(negedge clk);
    check_eq("accept_strobes", {ready, set_ong, clr_set, clr_way}, 4'hf);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check_eq("ongoing_set", m_ongoing, 1'b1);

    for (int n = 0; n < 200 && !ended && !aborted; n++) begin
      @(negedge clk);
      idx = int'(m_set) * int'(Ways) + int'(m_way);
      do_ls = 1'b0;
      nxt_ls = 2'd0;
      if (lookup_en) begin
        n_lookup++;
        lk_cycle[idx] = n;
        do_ls = 1'b1;
        nxt_ls = mem[idx];
      end
      if (i_pause && (incr_way || incr_set || clr_way)) paused_incr++;
      if (incr_way) n_incr_way++;
      if (incr_set) n_incr_set++;
      if (inval_en) begin
        n_inval++;
        inval_mask[idx] = 1'b1;
        mem[idx] = 2'd0;
      end
      if (dg_en) begin
        n_dg++;
        dg_mask[idx] = 1'b1;
        mem[idx] = 2'd2;
      end
      nxt_ready = 1'b0;
      if (wb_valid) begin
        n_wb_cyc++;
        last_wb_set = int'(wb_set);
        last_wb_way = int'(wb_way);
        if (idx == abort_idx) aborted = 1'b1;
        if (i_wb_ready) begin
          n_hs++;
          wb_run = 0;
        end else begin
          wb_run++;
          nxt_ready = (wb_run >= wb_delay);
        end
      end
      if (flush_done) begin
        n_done++;
        done_at = n;
        ended = 1'b1;
      end
      if (lookup_en && idx == pause_line) pause_left = 11;
      nxt_pause = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      if (!aborted) begin
        @(posedge clk); #1;
        i_pause    = nxt_pause;
        i_wb_ready = nxt_ready;
        if (do_ls) i_lookup_state = nxt_ls;
      end
    end
    if (!aborted) begin
      check_eq("sweep_ends", ended, 1'b1);
      check_eq("ongoing_cleared", m_ongoing, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_clean = 1'b0;
    i_pause = 1'b0;
    i_lookup_state = 2'd0;
    i_wb_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_outputs", {lookup_en, wb_valid, inval_en, flush_done, set_ong, clr_ong}, 6'h0);
    check_eq("rst_ongoing", m_ongoing, 1'b0);

    // All lines INVALID: 8 lines x 3 cycles, done 24 cycles after the accepting edge.
    run_sweep(-1, 0, -1, 1'b0);
    check_eq("inv_lookups", n_lookup, 8);
    check_eq("inv_wb", n_wb_cyc, 0);
    check_eq("inv_inval", n_inval, 0);
    check_eq("inv_done_at", done_at, 24);
    check_eq("inv_done_cnt", n_done, 1);
    check_eq("inv_incr_way", n_incr_way, 4);
    check_eq("inv_incr_set", n_incr_set, 3);
    check_eq("inv_final_pos", {m_set, m_way}, {2'd3, 1'b1});

    // (2,1) MODIFIED, ready held off 5 cycles: line takes 10 cycles instead of 3.
    clear_mem();
    mem[5] = 2'd3;
    run_sweep(-1, 5, -1, 1'b0);
    check_eq("mod_wb_cycles", n_wb_cyc, 6);
    check_eq("mod_handshakes", n_hs, 1);
    check_eq("mod_wb_set", last_wb_set, 2);
    check_eq("mod_wb_way", last_wb_way, 1);
    check_eq("mod_inval_mask", inval_mask, 8'h20);
    check_eq("mod_done_at", done_at, 31);

    // (0,0) SHARED and (3,1) EXCLUSIVE invalidated without writeback.
    clear_mem();
    mem[0] = 2'd1;
    mem[7] = 2'd2;
    run_sweep(-1, 0, -1, 1'b0);
    check_eq("clean_inval_mask", inval_mask, 8'h81);
    check_eq("clean_wb", n_wb_cyc, 0);
    check_eq("clean_done_at", done_at, 26);

    // pause during NEXT of (1,0): 10 stalled cycles, no strobes while paused.
    clear_mem();
    run_sweep(2, 0, -1, 1'b0);
    check_eq("pause_no_strobe", paused_incr, 0);
    check_eq("pause_gap", lk_cycle[3] - lk_cycle[2], 13);
    check_eq("pause_done_at", done_at, 34);

    // Reset in the middle of the writeback of (1,1).
    clear_mem();
    mem[3] = 2'd3;
    run_sweep(-1, 1000, 3, 1'b0);
    check_eq("rst_reached_wb", aborted, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_outputs",
             {lookup_en, wb_valid, inval_en, flush_done, set_ong, clr_ong, incr_set, clr_set,
              incr_way, clr_way}, 10'h0);
    i_wb_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_release_ready", ready, 1'b1);
    clear_mem();
    run_sweep(-1, 0, -1, 1'b0);
    check_eq("restart_first_lookup", lk_cycle[0], 0);
    check_eq("restart_lookups", n_lookup, 8);
    check_eq("restart_done_at", done_at, 24);

`ifdef L2_FLUSH_CLEAN_EN
    // Clean sweep: (1,0) MODIFIED written back and downgraded, (2,0) SHARED kept.
    clear_mem();
    mem[2] = 2'd3;
    mem[4] = 2'd1;
    run_sweep(-1, 0, -1, 1'b1);
    check_eq("cln_handshakes", n_hs, 1);
    check_eq("cln_dg_mask", dg_mask, 8'h04);
    check_eq("cln_inval", n_inval, 0);
    check_eq("cln_line_1_0", mem[2], 2'd2);
    check_eq("cln_line_2_0", mem[4], 2'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
